// File: rtl/mem_arbiter_rr_pkg.sv
// mem_arbiter_rr_pkg: shared types and helpers for the N-port memory arbiter
package mem_arbiter_rr_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_SETUP,
      ARB_BUSY
   } arb_state_t;

   typedef logic [127:0] lc3b_line;

   function automatic int gid_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational winner selection, round-robin from ptr or fixed from port 0
module rr_picker
   import mem_arbiter_rr_pkg::*;
#(
   parameter  int NUM_PORTS = 2,
   localparam int GID_W     = gid_width(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [GID_W-1:0]     ptr,
   input  logic                 mode,
   output logic [GID_W-1:0]     winner,
   output logic                 valid
);

   logic [GID_W-1:0] start;

   assign start = mode ? ptr : '0;

   // scan offsets from farthest to nearest so the requester closest to start wins last
   always_comb begin
      winner = '0;
      valid  = |req;
      for (int i = NUM_PORTS - 1; i >= 0; i--)
         if (req[(int'(start) + i) % NUM_PORTS]) winner = GID_W'((int'(start) + i) % NUM_PORTS);
   end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-requester arbiter onto a single physical memory port
module mem_arbiter_rr
   import mem_arbiter_rr_pkg::*;
#(
   parameter  int NUM_PORTS = 2,
   parameter  int ADDR_W    = 16,
   parameter  int LINE_W    = 128,
   parameter  int RR_MODE   = 1,
   parameter  int SETUP_CYC = 1,
   localparam int GID_W     = gid_width(NUM_PORTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        req_read,
   input  logic [NUM_PORTS-1:0]        req_write,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
   output logic [LINE_W-1:0]           req_rdata,
   output logic [NUM_PORTS-1:0]        req_resp,
   output logic                        pmem_read,
   output logic                        pmem_write,
   output logic [ADDR_W-1:0]           pmem_address,
   output logic [LINE_W-1:0]           pmem_wdata,
   input  logic [LINE_W-1:0]           pmem_rdata,
   input  logic                        pmem_resp,
   output logic                        grant_valid,
   output logic [GID_W-1:0]            grant_id
);

   arb_state_t           state, state_n;
   logic [GID_W-1:0]     rr_ptr, rr_ptr_n, grant_n, winner;
   logic [NUM_PORTS-1:0] req;
   logic                 any_req, busy, done;
   logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
   logic [LINE_W-1:0]    wdata_arr [NUM_PORTS];

   assign req  = req_read | req_write;
   assign busy = (state == ARB_BUSY);
   assign done = busy & (pmem_resp | ~req[grant_id]);

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
      assign addr_arr[k]  = req_addr[k*ADDR_W +: ADDR_W];
      assign wdata_arr[k] = req_wdata[k*LINE_W +: LINE_W];
   end

   rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
      .req    (req),
      .ptr    (rr_ptr),
      .mode   (RR_MODE != 0),
      .winner (winner),
      .valid  (any_req)
   );

   // owner, rotation pointer and arbitration state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ARB_IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_n;
         grant_id <= grant_n;
         rr_ptr   <= rr_ptr_n;
      end
   end

   // next state; a completion or a withdrawn request both release the port and rotate priority
   always_comb begin
      state_n  = (state == ARB_IDLE)  ? (any_req ? ((SETUP_CYC != 0) ? ARB_SETUP : ARB_BUSY) : ARB_IDLE) :
                 (state == ARB_SETUP) ? ARB_BUSY :
                 done                 ? ARB_IDLE : ARB_BUSY;
      grant_n  = (state == ARB_IDLE && any_req) ? winner : grant_id;
      rr_ptr_n = done ? ((int'(grant_id) == NUM_PORTS - 1) ? '0 : grant_id + 1'b1) : rr_ptr;
   end

   // memory strobes only in BUSY; a simultaneous read and write resolves to the write
   always_comb begin
      pmem_read          = busy & req_read[grant_id] & ~req_write[grant_id];
      pmem_write         = busy & req_write[grant_id];
      req_resp           = '0;
      req_resp[grant_id] = busy & pmem_resp;
   end

   assign grant_valid  = (state != ARB_IDLE);
   assign pmem_address = addr_arr[grant_id];
   assign pmem_wdata   = wdata_arr[grant_id];
   assign req_rdata    = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed scoreboard bench for round-robin and fixed-priority arbiters
module tb_mem_arbiter_rr;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]   a_read = '0, a_write = '0, a_resp;
   logic [63:0]  a_addr;
   logic [511:0] a_wdata = '0;
   logic [127:0] a_rdata, a_pwdata, a_prdata = '0;
   logic [15:0]  a_paddr;
   logic         a_pr, a_pw, a_presp = 1'b0, a_gv;
   logic [1:0]   a_gid;

   logic [1:0]   b_read = '0, b_write = '0, b_resp;
   logic [31:0]  b_addr;
   logic [255:0] b_wdata = '0;
   logic [127:0] b_rdata, b_pwdata, b_prdata = '0;
   logic [15:0]  b_paddr;
   logic         b_pr, b_pw, b_presp = 1'b0, b_gv;
   logic [0:0]   b_gid;

   int checks = 0, errors = 0, e;
   int qa[$], qb[$];
   logic [1:0] bv [3] = '{2'b01, 2'b11, 2'b10};
   int         be [3] = '{0, 0, 1};

   mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(16), .LINE_W(128), .RR_MODE(1), .SETUP_CYC(1)) dut_a (
      .clk(clk), .rst(rst), .req_read(a_read), .req_write(a_write), .req_addr(a_addr),
      .req_wdata(a_wdata), .req_rdata(a_rdata), .req_resp(a_resp), .pmem_read(a_pr),
      .pmem_write(a_pw), .pmem_address(a_paddr), .pmem_wdata(a_pwdata), .pmem_rdata(a_prdata),
      .pmem_resp(a_presp), .grant_valid(a_gv), .grant_id(a_gid)
   );

   mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(16), .LINE_W(128), .RR_MODE(0), .SETUP_CYC(0)) dut_b (
      .clk(clk), .rst(rst), .req_read(b_read), .req_write(b_write), .req_addr(b_addr),
      .req_wdata(b_wdata), .req_rdata(b_rdata), .req_resp(b_resp), .pmem_read(b_pr),
      .pmem_write(b_pw), .pmem_address(b_paddr), .pmem_wdata(b_pwdata), .pmem_rdata(b_prdata),
      .pmem_resp(b_presp), .grant_valid(b_gv), .grant_id(b_gid)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int k = 0; k < 4; k++) a_addr[k*16 +: 16] = 16'hA000 + 16'(k);
      b_addr = {16'hB001, 16'hB000};
      repeat (2) @(negedge clk);
      #1;
      chk("rst_gv", a_gv, 0);
      chk("rst_strobes", {a_pr, a_pw}, 0);
      chk("rst_resp", a_resp, 0);
      chk("rst_gid", a_gid, 0);
      chk("rst_addr", a_paddr, 16'hA000);
      chk("rst_b_gv", b_gv, 0);
      rst = 1'b0;
      // all four ports request continuously; memory answers on the third BUSY cycle
      a_read = 4'hF;
      for (int g = 0; g < 5; g++) qa.push_back(g % 4);
      for (int g = 0; g < 5; g++) begin
         @(negedge clk); #1;
         e = qa.pop_front();
         chk("rr_gid", a_gid, e);
         chk("rr_setup_gv", a_gv, 1);
         chk("rr_setup_strobes", {a_pr, a_pw}, 0);
         chk("rr_setup_addr", a_paddr, 16'hA000 + e);
         a_presp = 1'b1; #1;
         chk("rr_setup_resp_ignored", a_resp, 0);
         a_presp = 1'b0;
         @(negedge clk); #1;
         chk("rr_busy1_read", a_pr, 1);
         @(negedge clk); #1;
         chk("rr_busy2_read", a_pr, 1);
         chk("rr_busy2_noresp", a_resp, 0);
         @(negedge clk);
         a_presp  = 1'b1;
         a_prdata = {4{32'hC0DE0000 + 32'(e)}};
         #1;
         chk("rr_resp", a_resp, 4'b1 << e);
         chk("rr_rdata", a_rdata, {4{32'hC0DE0000 + 32'(e)}});
         @(negedge clk);
         a_presp = 1'b0; #1;
         chk("rr_idle_gap", a_gv, 0);
         chk("rr_idle_resp", a_resp, 0);
      end
      a_read = '0;
      // port 2 line write, rr_ptr is 1 so port 2 is the only candidate
      a_addr[32 +: 16]   = 16'h1234;
      a_wdata[256 +: 128] = {16{8'hA5}};
      a_write = 4'b0100;
      @(negedge clk); #1;
      chk("wr_gid", a_gid, 2);
      chk("wr_setup_addr", a_paddr, 16'h1234);
      chk("wr_setup_wdata", a_pwdata, {16{8'hA5}});
      chk("wr_setup_strobes", {a_pr, a_pw}, 0);
      @(negedge clk); #1;
      chk("wr_busy_write", a_pw, 1);
      chk("wr_busy_read", a_pr, 0);
      chk("wr_busy_addr", a_paddr, 16'h1234);
      chk("wr_busy_wdata", a_pwdata, {16{8'hA5}});
      a_presp = 1'b1; #1;
      chk("wr_resp", a_resp, 4'b0100);
      @(negedge clk);
      a_presp = 1'b0;
      a_write = '0; #1;
      chk("wr_idle", a_gv, 0);
      // rr_ptr is 3: port 1 wins, then withdraws mid-BUSY
      a_read = 4'b0010;
      @(negedge clk); #1;
      chk("ab_gid", a_gid, 1);
      @(negedge clk); #1;
      chk("ab_busy_read", a_pr, 1);
      a_read = '0; #1;
      chk("ab_drop_read", a_pr, 0);
      chk("ab_noresp", a_resp, 0);
      @(negedge clk); #1;
      chk("ab_idle", a_gv, 0);
      a_presp = 1'b1; #1;
      chk("ab_late_resp", a_resp, 0);
      @(negedge clk);
      a_presp = 1'b0;
      // rr_ptr is 2: port 3 wins over port 0, then reset hits mid-BUSY
      a_read = 4'b1001;
      @(negedge clk); #1;
      chk("rs_gid", a_gid, 3);
      @(negedge clk); #1;
      chk("rs_busy_read", a_pr, 1);
      #2 rst = 1'b1;
      #1;
      chk("rs_strobe_drop", a_pr, 0);
      chk("rs_gv_drop", a_gv, 0);
      @(negedge clk); #1;
      rst = 1'b0;
      qa.push_back(0);
      @(negedge clk); #1;
      e = qa.pop_front();
      chk("rs_rearb_gid", a_gid, e);
      chk("rs_rearb_gv", a_gv, 1);
      a_read = '0;
      // fixed priority, no setup cycle: port 0 beats port 1 even after port 0 was just served
      for (int i = 0; i < 3; i++) begin
         b_read = bv[i];
         qb.push_back(be[i]);
         @(negedge clk); #1;
         e = qb.pop_front();
         chk("fp_gid", b_gid, e);
         chk("fp_gv", b_gv, 1);
         chk("fp_read", b_pr, 1);
         chk("fp_addr", b_paddr, 16'hB000 + e);
         b_presp  = 1'b1;
         b_prdata = {4{32'h5EED0000 + 32'(i)}};
         #1;
         chk("fp_resp", b_resp, 2'b1 << e);
         chk("fp_rdata", b_rdata, {4{32'h5EED0000 + 32'(i)}});
         @(negedge clk);
         b_presp = 1'b0;
         b_read  = '0; #1;
         chk("fp_idle", b_gv, 0);
         b_presp = 1'b1; #1;
         chk("fp_idle_resp", b_resp, 0);
         b_presp = 1'b0;
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-requester arbiter between cache-level clients (I-cache, D-cache, later victim buffer or prefetcher) and the single physical memory port.
- Generalises the two-port I/D arbiter:
  - parametrised port count, address width and line width;
  - selectable fixed-priority or round-robin policy;
  - carries the address/data mux internally;
  - handles request withdrawal.
- Sits between the cache miss FSMs and pmem.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- ADDR_W, 16, address width (lc3b word address).
- LINE_W, 128, cache line width in bits.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (port 0 highest).
- SETUP_CYC, 1, cycles the grant mux is held before strobing pmem (0 or 1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_read  in  NUM_PORTS  per-port line read request.
- req_write  in  NUM_PORTS  per-port line write request.
- req_addr  in  NUM_PORTS*ADDR_W  per-port address, port k at [k*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*LINE_W  per-port write line.
- req_rdata  out  LINE_W  pmem_rdata broadcast to all ports.
- req_resp  out  NUM_PORTS  one-hot completion pulse to the granted port.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_W  granted port address.
- pmem_wdata  out  LINE_W  granted port write line.
- pmem_rdata  in  LINE_W  memory read line.
- pmem_resp  in  1  memory completion.
- grant_valid  out  1  a port currently owns memory (SETUP or BUSY).
- grant_id  out  GID_W  owning port index; GID_W = max(1, clog2(NUM_PORTS)).

Behaviour:
- Reset (async, rst=1), with all outputs driven from registered state:
  - state=IDLE, grant_id=0, rr_ptr=0;
  - grant_valid=0, pmem_read=0, pmem_write=0, req_resp=0;
  - pmem_address and pmem_wdata select port 0.
- A port requests when req_read|req_write is set. Requesters hold address, data and strobe stable until their req_resp.
- IDLE:
  - No request: stay.
  - Otherwise pick a winner:
    - RR_MODE=1: first requesting port scanning from rr_ptr upward, modulo NUM_PORTS.
    - RR_MODE=0: lowest requesting index.
  - Register the winner into grant_id.
  - Next state is SETUP if SETUP_CYC=1, else BUSY.
- SETUP:
  - grant_valid=1; the mux drives pmem_address/pmem_wdata from grant_id; both strobes are 0.
  - Next state BUSY unconditionally.
- BUSY:
  - pmem_read = req_read[grant_id] & ~req_write[grant_id]; pmem_write = req_write[grant_id].
  - A simultaneous read and write from one port is a protocol violation; write wins.
  - req_resp[grant_id] = pmem_resp, combinational, same cycle. req_rdata = pmem_rdata at all times.
  - On pmem_resp: next state IDLE; rr_ptr <= (grant_id+1) mod NUM_PORTS.
  - If the granted port drops both strobes before pmem_resp (abort): next state IDLE, no req_resp, rr_ptr advanced as on completion.
- Arbitration latency:
  - request in IDLE to first pmem strobe = 1+SETUP_CYC cycles;
  - minimum of one IDLE cycle between consecutive grants.
- Requests arriving during SETUP/BUSY from other ports are ignored until IDLE. Fixed priority can starve high-index ports; round-robin guarantees service within NUM_PORTS grants.
- pmem_resp outside BUSY is ignored; req_resp stays 0.
- Reset asserted mid-transaction: immediate return to IDLE, strobes drop asynchronously, and the in-flight memory transaction is abandoned. The memory model must also reset.
- The NUM_PORTS=2, RR_MODE=0, SETUP_CYC=1 configuration replaces the I/D arbiter, with D-cache mapped to port 0.

Decomposition:
- lc3b_types package gains:
  - arb_state_t enum {ARB_IDLE, ARB_SETUP, ARB_BUSY};
  - lc3b_line typedef, if not already present.
- Sub-module rr_picker:
  - combinational;
  - inputs: request vector, rr_ptr, mode;
  - outputs: winner index and any-valid;
  - unit-tested separately.

Test Plan:
- NUM_PORTS=2, RR_MODE=0: ports 0 and 1 both read in the same cycle → port 0 granted, pmem_read at cycle 2, req_resp[0] with pmem_resp; port 1 granted next.
- NUM_PORTS=4, RR_MODE=1: all ports hold requests continuously, memory responds after 3 cycles → grant order 0,1,2,3,0; each req_resp exactly once per grant.
- Port 2 write with addr 0x1234, wdata 0xA5…A5 → pmem_address=0x1234 and pmem_wdata match from SETUP onward; pmem_write only in BUSY; pmem_read stays 0.
- Granted port drops its read mid-BUSY before pmem_resp → IDLE next cycle, no req_resp; a late pmem_resp is ignored.
- rst pulsed during BUSY → strobes 0 the same cycle, grant_valid=0; after release, new requests are arbitrated from rr_ptr=0.
- SETUP_CYC=0: single request → pmem strobe on the cycle after the request; req_rdata equals pmem_rdata on the resp cycle.
